// File: rtl/cineraria_core_irqctrl.sv
// Avalon-MM interrupt controller: sync, edge/level capture, mask,
// lowest-index priority vector and a registered CPU irq line.
module cineraria_core_irqctrl #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [15:0] EDGE_MASK = 16'h0001
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    localparam logic [NUM_IRQ-1:0] EDGE_SRC = EDGE_MASK[NUM_IRQ-1:0];

    logic [NUM_IRQ-1:0] s1, s2, s3;
    logic [NUM_IRQ-1:0] pending, swirq, enable;
    logic [NUM_IRQ-1:0] edge_det, effective, active;
    logic [NUM_IRQ-1:0] wd, w1c, pending_next;
    logic [15:0]        vector, vector_next, rd_mux;
    logic [3:0]         idx;
    logic               wr;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[NUM_IRQ-1:0];
    assign edge_det  = s2 & ~s3;
    assign effective = pending | swirq;
    assign active    = effective & enable;
    assign w1c       = (wr && address == 3'd0) ? wd : '0;

    // A fresh edge beats a simultaneous W1C on the same bit.
    assign pending_next = (EDGE_SRC & ((pending & ~w1c) | edge_det))
                        | (~EDGE_SRC & s2);

    always_comb begin
        idx = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) idx = 4'(i);
        end
        vector_next = {|active, 11'd0, idx};
    end

    always_comb begin
        case (address)
            3'd0:    rd_mux = 16'(effective);
            3'd1:    rd_mux = 16'(enable);
            3'd2:    rd_mux = 16'(enable);
            3'd3:    rd_mux = 16'(enable);
            3'd4:    rd_mux = 16'(active);
            3'd5:    rd_mux = vector;
            3'd6:    rd_mux = 16'(swirq);
            default: rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            pending  <= '0;
            swirq    <= '0;
            enable   <= '0;
            vector   <= 16'd0;
            irq      <= 1'b0;
            readdata <= 16'd0;
        end else begin
            s1       <= irq_in;
            s2       <= s1;
            s3       <= s2;
            pending  <= pending_next;
            vector   <= vector_next;
            irq      <= |active;
            readdata <= rd_mux;
            if (wr) begin
                case (address)
                    3'd1:    enable <= wd;
                    3'd2:    enable <= enable | wd;
                    3'd3:    enable <= enable & ~wd;
                    3'd6:    swirq  <= wd;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cineraria_core_irqctrl.sv
// Directed bench for cineraria_core_irqctrl with immediate-assertion
// checks; inputs change and outputs are sampled on the falling edge.
module tb_cineraria_core_irqctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_in;
    logic        irq;

    int tests  = 0;
    int failed = 0;

    cineraria_core_irqctrl #(.NUM_IRQ(8), .EDGE_MASK(16'h0001)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a,
                          input logic [15:0] exp);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chk(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'd0;
        irq_in     = 8'd0;
        #23;
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_rdata", readdata, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // timer edge source
        wr_reg(3'd1, 16'h0001);
        @(negedge clk);
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("edge_irq_e2", {15'd0, irq}, 16'd0);
        @(negedge clk);
        chk("edge_irq_e3", {15'd0, irq}, 16'd1);
        rd_chk("edge_vector", 3'd5, 16'h8000);
        rd_chk("edge_pending", 3'd0, 16'h0001);
        wr_reg(3'd0, 16'h0001);
        chk("w1c_irq_w", {15'd0, irq}, 16'd1);
        @(negedge clk);
        chk("w1c_irq_w1", {15'd0, irq}, 16'd0);
        rd_chk("w1c_pending", 3'd0, 16'h0000);

        // level sources and priority
        wr_reg(3'd1, 16'h00FF);
        irq_in = 8'h28;
        idle(5);
        rd_chk("lvl_vector_3", 3'd5, 16'h8003);
        rd_chk("lvl_active", 3'd4, 16'h0028);
        irq_in = 8'h20;
        idle(5);
        rd_chk("lvl_vector_5", 3'd5, 16'h8005);
        wr_reg(3'd0, 16'h0020);
        rd_chk("lvl_w1c_noeff", 3'd0, 16'h0020);
        @(negedge clk);
        irq_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("lvl_drop_e2", {15'd0, irq}, 16'd1);
        @(negedge clk);
        chk("lvl_drop_e3", {15'd0, irq}, 16'd0);
        rd_chk("lvl_vector_0", 3'd5, 16'h0000);

        // masking and software irq
        wr_reg(3'd1, 16'h0000);
        wr_reg(3'd6, 16'h0040);
        idle(2);
        chk("mask_irq", {15'd0, irq}, 16'd0);
        rd_chk("mask_active", 3'd4, 16'h0000);
        rd_chk("swirq_rd", 3'd6, 16'h0040);
        rd_chk("swirq_eff", 3'd0, 16'h0040);
        wr_reg(3'd2, 16'h0040);
        chk("eset_irq_w", {15'd0, irq}, 16'd0);
        @(negedge clk);
        chk("eset_irq_w1", {15'd0, irq}, 16'd1);
        rd_chk("eset_vector", 3'd5, 16'h8006);
        rd_chk("eset_rd", 3'd2, 16'h0040);
        wr_reg(3'd2, 16'h0001);
        rd_chk("eset_or", 3'd1, 16'h0041);
        wr_reg(3'd3, 16'h0040);
        @(negedge clk);
        chk("eclr_irq", {15'd0, irq}, 16'd0);
        rd_chk("eclr_rd", 3'd3, 16'h0001);
        wr_reg(3'd6, 16'h0000);

        // W1C colliding with a new edge on bit 0
        wr_reg(3'd1, 16'h0001);
        @(negedge clk);
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        idle(4);
        chk("coll_pre_irq", {15'd0, irq}, 16'd1);
        @(negedge clk);
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        @(negedge clk);
        address    = 3'd0;
        writedata  = 16'h0001;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        idle(2);
        chk("coll_irq", {15'd0, irq}, 16'd1);
        rd_chk("coll_pending", 3'd0, 16'h0001);
        wr_reg(3'd0, 16'h0001);
        rd_chk("coll_cleared", 3'd0, 16'h0000);

        // bounds for NUM_IRQ=8
        wr_reg(3'd1, 16'hFFFF);
        rd_chk("bnd_enable", 3'd1, 16'h00FF);
        wr_reg(3'd6, 16'hFF00);
        rd_chk("bnd_swirq", 3'd6, 16'h0000);
        wr_reg(3'd7, 16'hFFFF);
        rd_chk("bnd_addr7", 3'd7, 16'h0000);

        // asynchronous reset mid-traffic
        wr_reg(3'd6, 16'h0002);
        idle(2);
        @(negedge clk);
        address    = 3'd1;
        chipselect = 1'b1;
        @(negedge clk);
        chk("pre_rst_irq", {15'd0, irq}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_irq", {15'd0, irq}, 16'd0);
        chk("arst_rdata", readdata, 16'd0);
        chipselect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd_chk("post_enable", 3'd1, 16'h0000);
        rd_chk("post_pending", 3'd0, 16'h0000);
        rd_chk("post_vector", 3'd5, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
